// File: rtl/fifo_rd_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_sched_if
//  Purpose  : Bundle of the FIFO read port and the per-consumer burst
//             request / data handshake served by fifo_rd_sched.
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_rd_sched_if #(
  parameter int DSIZE  = 8,
  parameter int NREQ   = 4,
  parameter int BLEN_W = 4
) ();

  // Consumer request side
  logic [NREQ-1:0]        req;
  logic [NREQ*BLEN_W-1:0] blen;
  logic [NREQ-1:0]        rd_ready;
  logic [NREQ-1:0]        rd_valid;
  logic [DSIZE-1:0]       rd_data;
  logic                   rd_last;
  logic [NREQ-1:0]        gnt;
  logic                   done;
  logic                   trunc;

  // FIFO read port
  logic                   rempty;
  logic [DSIZE-1:0]       rdata;
  logic                   rinc;

  // Scheduler side
  modport slave (
    input  req, blen, rd_ready, rempty, rdata,
    output rinc, gnt, rd_valid, rd_data, rd_last, done, trunc
  );

  // FIFO plus consumers side
  modport master (
    output req, blen, rd_ready, rempty, rdata,
    input  rinc, gnt, rd_valid, rd_data, rd_last, done, trunc
  );

endinterface
`default_nettype wire

// File: rtl/fifo_rd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_sched
//  Purpose  : Read-side burst scheduler for the async FIFO. Shares the single
//             read port between NREQ consumers, granting whole bursts
//             round-robin and ending each burst on length or empty-timeout.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_rd_sched #(
  parameter int DSIZE  = 8,
  parameter int NREQ   = 4,
  parameter int BLEN_W = 4,
  parameter int TMO    = 15
) (
  input  logic            rclk,
  input  logic            rrst_n,
  fifo_rd_sched_if.slave  bus
);

  localparam int c_ptr_w  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_ecnt_w = $clog2(TMO + 1);

  localparam logic [c_ptr_w-1:0]  c_rr_rst  = c_ptr_w'(NREQ - 1);
  localparam logic [c_ecnt_w-1:0] c_tmo_m1  = c_ecnt_w'(TMO - 1);
  localparam logic [c_ecnt_w-1:0] c_tmo_sat = c_ecnt_w'(TMO);
  localparam logic [BLEN_W-1:0]   c_one     = BLEN_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  // Registered state
  state_t               r_state;
  logic [NREQ-1:0]      r_gnt;
  logic [c_ptr_w-1:0]   r_gidx;
  logic [c_ptr_w-1:0]   r_rr;
  logic [BLEN_W-1:0]    r_cnt;
  logic [c_ecnt_w-1:0]  r_ecnt;
  logic                 r_done;
  logic                 r_trunc;

  // Combinational helpers
  logic [BLEN_W-1:0]    w_blen_arr [NREQ];
  logic [c_ptr_w-1:0]   w_idx;
  logic [c_ptr_w-1:0]   w_win;
  logic                 w_found;
  logic [BLEN_W-1:0]    w_blen_win;
  logic [BLEN_W-1:0]    w_blen_load;
  logic                 w_in_burst;
  logic                 w_pop;
  logic                 w_last_beat;
  logic                 w_tmo_hit;
  logic [NREQ-1:0]      w_valid;
  logic [DSIZE-1:0]     w_rd_data;

  // Split the packed burst-length bus into one entry per consumer
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_blen_arr[i] = bus.blen[i*BLEN_W +: BLEN_W];
    end
  end

  // Round-robin search: first set request above the last-served index
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = c_ptr_w'((int'(r_rr) + k) % NREQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // A zero length request still moves one beat
  always_comb begin
    w_blen_win  = w_blen_arr[w_win];
    w_blen_load = (w_blen_win == '0) ? c_one : w_blen_win;
  end

  // Burst-phase pop / last / timeout decode and per-consumer valid
  always_comb begin
    w_in_burst  = (r_state == S_BURST);
    w_pop       = w_in_burst & ~bus.rempty & bus.rd_ready[r_gidx];
    w_last_beat = (r_cnt == c_one);
    w_tmo_hit   = w_in_burst & bus.rempty & (r_ecnt == c_tmo_m1);
    w_valid     = '0;
    if (w_in_burst && !bus.rempty) begin
      w_valid = r_gnt;
    end
  end

  // Arbitration and burst sequencing; done/trunc are one-cycle pulses
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_gidx  <= '0;
      r_rr    <= c_rr_rst;
      r_cnt   <= '0;
      r_ecnt  <= '0;
      r_done  <= 1'b0;
      r_trunc <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_trunc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= NREQ'(1) << w_win;
            r_gidx  <= w_win;
            r_cnt   <= w_blen_load;
            r_ecnt  <= '0;
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_pop) begin
            // A pop implies data was present, so the empty run restarts
            r_cnt  <= r_cnt - c_one;
            r_ecnt <= '0;
            if (w_last_beat) begin
              r_state <= S_IDLE;
              r_gnt   <= '0;
              r_rr    <= r_gidx;
              r_done  <= 1'b1;
            end
          end else if (bus.rempty) begin
            if (r_ecnt != c_tmo_sat) begin
              r_ecnt <= r_ecnt + 1'b1;
            end
            if (w_tmo_hit) begin
              r_state <= S_IDLE;
              r_gnt   <= '0;
              r_rr    <= r_gidx;
              r_done  <= 1'b1;
              r_trunc <= 1'b1;
            end
          end else begin
            // Data present but consumer stalled: not an empty condition
            r_ecnt <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign w_rd_data    = bus.rdata;
  assign bus.rd_data  = w_rd_data;
  assign bus.rinc     = w_pop;
  assign bus.rd_last  = w_pop & w_last_beat;
  assign bus.rd_valid = w_valid;
  assign bus.gnt      = r_gnt;
  assign bus.done     = r_done;
  assign bus.trunc    = r_trunc;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_sched
//  Purpose  : Directed bench for fifo_rd_sched with a small FIFO read model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_rd_sched;

  localparam int DSIZE  = 8;
  localparam int NREQ   = 4;
  localparam int BLEN_W = 4;
  localparam int TMO    = 15;

  logic rclk   = 1'b0;
  logic rrst_n = 1'b0;

  fifo_rd_sched_if #(.DSIZE(DSIZE), .NREQ(NREQ), .BLEN_W(BLEN_W)) bus ();

  fifo_rd_sched #(.DSIZE(DSIZE), .NREQ(NREQ), .BLEN_W(BLEN_W), .TMO(TMO)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  always #5 rclk = ~rclk;

  // FIFO read-side model: words written by the stimulus, popped by rinc
  logic [7:0] fmem [0:63];
  int fwr = 0;
  int frd = 0;
  int over_pop = 0;

  assign bus.rempty = (frd == fwr);
  assign bus.rdata  = fmem[frd[5:0]];

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) frd <= 0;
    else if (bus.rinc) frd <= frd + 1;
  end

  always @(posedge rclk) begin
    if (rrst_n && bus.rinc && bus.rempty) over_pop <= over_pop + 1;
  end

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge rclk);
    #1;
  endtask

  // Hold reset, reload the FIFO with n words A0,A1,..., release reset
  task automatic do_reset(input int n);
    rrst_n = 1'b0;
    bus.req = '0;
    bus.blen = '0;
    bus.rd_ready = '0;
    @(negedge rclk);
    #1;
    fwr = n;
    for (int i = 0; i < n; i++) fmem[i] = 8'hA0 + 8'(i);
    @(negedge rclk);
    #1;
    rrst_n = 1'b1;
  endtask

  typedef struct {
    int          load;   // >0: reset and preload this many words first
    logic [3:0]  req;
    logic [15:0] blen;
    logic [3:0]  rdy;
    logic [3:0]  gnt;
    logic [3:0]  vld;
    logic        rinc;
    logic        last;
    logic        done;
    logic        trunc;
    logic        chkd;
    logic [7:0]  data;
    int          left;   // >=0: words expected to remain in the FIFO
  } vec_t;

  function automatic vec_t mk(input int ld, input logic [3:0] rq, input logic [15:0] bl,
                              input logic [3:0] rd, input logic [3:0] g, input logic [3:0] v,
                              input logic ri, input logic la, input logic dn, input logic tr,
                              input logic cd, input logic [7:0] d, input int lf);
    vec_t r;
    r.load = ld; r.req = rq; r.blen = bl; r.rdy = rd; r.gnt = g; r.vld = v;
    r.rinc = ri; r.last = la; r.done = dn; r.trunc = tr; r.chkd = cd; r.data = d;
    r.left = lf;
    return r;
  endfunction

  vec_t tbl [27];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pops, emp, lasts, dn, lastpop;
    logic seen;

    // Round robin: all requesting, length 1, FIFO never empty
    tbl[0]  = mk(16, 4'hF, 16'h1111, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, -1);
    tbl[1]  = mk( 0, 4'hF, 16'h1111, 4'hF, 4'h1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, -1);
    tbl[2]  = mk( 0, 4'hF, 16'h1111, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, -1);
    tbl[3]  = mk( 0, 4'hF, 16'h1111, 4'hF, 4'h2, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, -1);
    tbl[4]  = mk( 0, 4'hF, 16'h1111, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, -1);
    tbl[5]  = mk( 0, 4'hF, 16'h1111, 4'hF, 4'h4, 4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, -1);
    tbl[6]  = mk( 0, 4'hF, 16'h1111, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, -1);
    tbl[7]  = mk( 0, 4'hF, 16'h1111, 4'hF, 4'h8, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, -1);
    tbl[8]  = mk( 0, 4'hF, 16'h1111, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, -1);
    tbl[9]  = mk( 0, 4'hF, 16'h1111, 4'hF, 4'h1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA4, -1);
    tbl[10] = mk( 0, 4'h0, 16'h1111, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, -1);
    tbl[11] = mk( 0, 4'h0, 16'h1111, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, -1);
    // Single 3-beat burst from a 5-word FIFO; req drops mid-burst
    tbl[12] = mk( 5, 4'h1, 16'h0003, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, -1);
    tbl[13] = mk( 0, 4'h0, 16'h0003, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, -1);
    tbl[14] = mk( 0, 4'h0, 16'h0003, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, -1);
    tbl[15] = mk( 0, 4'h0, 16'h0003, 4'h1, 4'h1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, -1);
    tbl[16] = mk( 0, 4'h0, 16'h0003, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, -1);
    tbl[17] = mk( 0, 4'h0, 16'h0003, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,  2);
    // Backpressure: consumer 1, length 4, ready toggling
    tbl[18] = mk( 8, 4'h2, 16'h0040, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, -1);
    tbl[19] = mk( 0, 4'h2, 16'h0040, 4'h2, 4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, -1);
    tbl[20] = mk( 0, 4'h2, 16'h0040, 4'h0, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, -1);
    tbl[21] = mk( 0, 4'h2, 16'h0040, 4'h2, 4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, -1);
    tbl[22] = mk( 0, 4'h2, 16'h0040, 4'h0, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, -1);
    tbl[23] = mk( 0, 4'h2, 16'h0040, 4'h2, 4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA2, -1);
    tbl[24] = mk( 0, 4'h2, 16'h0040, 4'h0, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, -1);
    tbl[25] = mk( 0, 4'h0, 16'h0040, 4'h2, 4'h2, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, -1);
    tbl[26] = mk( 0, 4'h0, 16'h0040, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00,  4);

    for (int i = 0; i < 27; i++) begin
      if (tbl[i].load > 0) do_reset(tbl[i].load);
      else nxt();
      bus.req      = tbl[i].req;
      bus.blen     = tbl[i].blen;
      bus.rd_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d gnt/vld/rinc/last/done/trunc", i),
          32'({bus.gnt, bus.rd_valid, bus.rinc, bus.rd_last, bus.done, bus.trunc}),
          32'({tbl[i].gnt, tbl[i].vld, tbl[i].rinc, tbl[i].last, tbl[i].done, tbl[i].trunc}));
      if (tbl[i].chkd) chk($sformatf("row%0d rd_data", i), 32'(bus.rd_data), 32'(tbl[i].data));
      if (tbl[i].left >= 0) chk($sformatf("row%0d fifo_left", i), 32'(fwr - frd), 32'(tbl[i].left));
    end

    // Empty timeout: consumer 2 asks for 8 but only 2 words exist
    do_reset(2);
    bus.req = 4'hC; bus.blen = 16'h1800; bus.rd_ready = 4'hF;
    #1;
    pops = 0; emp = 0; lasts = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      nxt();
      if (bus.done) seen = 1'b1;
      else if (bus.gnt == 4'h4) begin
        if (bus.rinc) pops++;
        else if (bus.rempty) emp++;
        if (bus.rd_last) lasts++;
      end
    end
    chk("tmo done_seen", 32'(seen), 32'd1);
    chk("tmo trunc", 32'(bus.trunc), 32'd1);
    chk("tmo gnt_cleared", 32'(bus.gnt), 32'h0);
    chk("tmo pops", 32'(pops), 32'd2);
    chk("tmo empty_cycles", 32'(emp), 32'(TMO));
    chk("tmo rd_last", 32'(lasts), 32'd0);
    nxt();
    chk("tmo next_grant", 32'(bus.gnt), 32'h8);
    chk("tmo trunc_pulse", 32'(bus.trunc), 32'd0);

    // blen=0 behaves as a single beat
    do_reset(2);
    bus.req = 4'h1; bus.blen = 16'h0000; bus.rd_ready = 4'hF;
    nxt();
    bus.req = 4'h0;
    #1;
    pops = 0; lasts = 0; dn = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.rinc) pops++;
      if (bus.rd_last) lasts++;
      if (bus.done) dn++;
      nxt();
    end
    chk("blen0 pops", 32'(pops), 32'd1);
    chk("blen0 rd_last", 32'(lasts), 32'd1);
    chk("blen0 done", 32'(dn), 32'd1);
    chk("blen0 fifo_left", 32'(fwr - frd), 32'd1);

    // req drop and blen change after grant do not shorten the burst
    do_reset(8);
    bus.req = 4'h1; bus.blen = 16'h0004; bus.rd_ready = 4'hF;
    nxt();
    bus.req = 4'h0; bus.blen = 16'h0001;
    #1;
    pops = 0; lastpop = 0; dn = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.rinc) pops++;
      if (bus.rd_last) lastpop = pops;
      if (bus.done) dn++;
      nxt();
    end
    chk("hold pops", 32'(pops), 32'd4);
    chk("hold last_on_beat", 32'(lastpop), 32'd4);
    chk("hold done", 32'(dn), 32'd1);

    // Reset during the 2nd beat of a 4-beat burst
    do_reset(8);
    bus.req = 4'h1; bus.blen = 16'h0004; bus.rd_ready = 4'hF;
    #1;
    nxt();
    nxt();
    chk("mrst beat2_rinc", 32'(bus.rinc), 32'd1);
    rrst_n = 1'b0;
    #1;
    chk("mrst gnt", 32'(bus.gnt), 32'h0);
    chk("mrst rinc", 32'(bus.rinc), 32'd0);
    chk("mrst rd_valid", 32'(bus.rd_valid), 32'h0);
    do_reset(8);
    bus.req = 4'hF; bus.blen = 16'h1111; bus.rd_ready = 4'hF;
    #1;
    nxt();
    chk("mrst first_grant", 32'(bus.gnt), 32'h1);

    chk("pop_while_empty", 32'(over_pop), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_sched.md
Name: fifo_rd_sched

Overview:
- Read-side scheduler for the async FIFO. Shares the single FIFO read port (rinc/rdata/rempty) between NREQ consumers.
- Grants whole bursts round-robin and sequences rinc against rempty and the granted consumer's ready.
- Ends a burst on length exhaustion or on an empty-timeout.
- Lives entirely in the read clock domain, next to the read-pointer/empty logic.

Parameters:
- DSIZE, 8, FIFO data width.
- NREQ, 4, number of consumers (2..8).
- BLEN_W, 4, width of each requested burst length.
- TMO, 15, consecutive empty cycles inside a burst before forced termination (1..255).

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-consumer burst request (level).
- blen  in  NREQ*BLEN_W  per-consumer burst length, slice i = blen[i*BLEN_W +: BLEN_W]; 0 is treated as 1.
- rempty  in  1  FIFO empty flag (registered, from the read-pointer block).
- rdata  in  DSIZE  FIFO read data, valid at the current read address while rempty=0.
- rinc  out  1  pop strobe to the FIFO.
- gnt  out  NREQ  one-hot grant, held for the whole burst.
- rd_valid  out  NREQ  per-consumer data valid.
- rd_ready  in  NREQ  per-consumer ready.
- rd_data  out  DSIZE  equals rdata (combinational passthrough).
- rd_last  out  1  final beat of the burst (qualified by the pop).
- done  out  1  one-cycle pulse when a burst ends.
- trunc  out  1  one-cycle pulse with done when the burst ended by timeout.

Behaviour:
- Reset (rrst_n=0, async): state=IDLE; gnt=0, rinc=0, rd_valid=0, rd_last=0, done=0, trunc=0; beat count=0; empty counter=0; round-robin pointer=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, BURST.
- IDLE, arbitration:
  - If req!=0, the winner is the first set bit searching upward from (rr_ptr+1) mod NREQ.
  - At the clock edge, register gnt=onehot(winner), load cnt=max(blen[winner],1), clear the empty counter, go to BURST.
  - Latency: req seen at edge n gives gnt and first possible pop in cycle n+1.
  - If req=0, stay in IDLE.
- BURST, with granted index g:
  - rd_valid[g]=~rempty; all other rd_valid bits are 0.
  - pop = ~rempty & rd_ready[g]; rinc = pop (combinational, same cycle).
  - rinc is never asserted when rempty=1.
  - rd_last = pop & (cnt==1).
  - Each pop decrements cnt.
  - Empty counter: increments on each cycle with rempty=1; clears on any cycle with rempty=0.
- BURST exit by length:
  - On the pop with cnt==1, next state is IDLE, gnt clears, rr_ptr=g.
  - done=1 in the cycle after the last pop (registered).
- BURST exit by timeout:
  - When the empty counter reaches TMO with cnt>0, next state is IDLE and rr_ptr=g.
  - done=1 and trunc=1 together in the following cycle.
  - No rd_last is issued.
- Timeout vs final pop: both cannot occur in the same cycle, because a pop requires rempty=0, which clears the empty counter.
- rempty=0 with rd_ready[g]=0: no pop and no timeout progress; the burst waits indefinitely for ready.
- req[g] deasserting mid-burst is ignored; the burst completes or times out.
- Requests from other consumers during BURST are not serviced until the return to IDLE. One IDLE cycle always separates consecutive bursts, so the maximum throughput is blen beats per blen+1 cycles.
- blen is sampled only at grant; later changes have no effect on the current burst.
- Fairness: with all req high, grants rotate 0,1,2,...,NREQ-1,0.
- Reset mid-burst: all state returns to reset values immediately. No pop is issued after reset assertion because rinc is gated by state.
- Widths:
  - cnt is BLEN_W bits.
  - Empty counter is ceil(log2(TMO+1)) bits and saturates at TMO.

Test Plan:
- Single burst: after reset, req=4'b0001, blen[0]=3, FIFO holds 5 words A..E, rd_ready[0]=1. Expect gnt=0001 from cycle 1, rinc high 3 consecutive cycles delivering A,B,C, rd_last on C, done one cycle later, FIFO left holding D,E.
- Round-robin: req=4'b1111, all blen=1, FIFO never empty. Expect grant order 0,1,2,3,0, one beat each, one IDLE cycle between bursts.
- Backpressure: blen[1]=4, rd_ready[1] toggling 1,0,1,0,... Expect rinc only in ready-high cycles, exactly 4 pops, rd_last on the 4th pop.
- Empty timeout: TMO=15, blen[2]=8, FIFO holds 2 words and no further writes. Expect 2 pops, rempty high 15 cycles, then done=1 and trunc=1 together, no rd_last, gnt cleared, next grant goes to requester 3.
- blen=0 and ignored mid-burst changes: blen[0]=0, 2 words present. Expect exactly 1 pop with rd_last. Separately, deassert req mid-burst: the burst still completes its full length.
- Reset mid-burst: assert rrst_n=0 during the 2nd beat of a 4-beat burst. Expect gnt, rinc and rd_valid at 0 immediately. After release, requester 0 is served first.
